// File: rtl/pong_game_ctrl_pkg.sv
// Shared types for the pong match sequencer.
// State codes are also decoded by debug/overlay logic.
package pong_game_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SERVE  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_SCORED = 3'd4,
    ST_OVER   = 3'd5
  } state_t;

  function automatic int clamp1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Handshake between the match sequencer and the ball/paddle datapath.
// master = sequencer side, slave = physics side.
interface pong_game_ctrl_if;

  logic phys_step;
  logic phys_done;
  logic miss_l;
  logic miss_r;
  logic ball_reset;
  logic serve_dir;

  modport master (
    output phys_step, ball_reset, serve_dir,
    input  phys_done, miss_l, miss_r
  );

  modport slave (
    input  phys_step, ball_reset, serve_dir,
    output phys_done, miss_l, miss_r
  );

endinterface

// File: rtl/pong_game_ctrl_frame_timer.sv
// Frame down-counter: load, decrement on frame tick, expire on last tick.
// Load values are pre-clamped to >= 1 by the caller.
module pong_game_ctrl_frame_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = tick && (cnt == W'(1));

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: attract, serve, play, point pause, game over.
// Issues one physics step per frame and keeps score and serve direction.
module pong_game_ctrl
  import pong_game_ctrl_pkg::*;
#(
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int PAUSE_FRAMES = 30,
  parameter int STEP_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               start_btn,
  pong_game_ctrl_if.master   phys,
  output logic               paddle_en,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [2:0]         game_state,
  output logic               winner,
  output logic               step_err
);

  localparam int SERVE_LD = clamp1(SERVE_FRAMES);
  localparam int PAUSE_LD = clamp1(PAUSE_FRAMES);
  localparam int FMAX = (SERVE_LD > PAUSE_LD) ? SERVE_LD : PAUSE_LD;
  localparam int FW = $clog2(FMAX + 1);
  localparam int TW = (STEP_TIMEOUT < 1) ? 1 : $clog2(STEP_TIMEOUT + 1);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
  localparam logic [TW-1:0] TMO = TW'(STEP_TIMEOUT);

  state_t state, state_nxt;

  logic               start_q;
  logic               st_edge;
  logic [TW-1:0]      tcnt;
  logic               timeout;
  logic               f_load;
  logic [FW-1:0]      f_val;
  logic               f_exp;
  logic               hit_l;
  logic               hit_r;
  logic               hit_b;
  logic [SCORE_W-1:0] sl_inc;
  logic [SCORE_W-1:0] sr_inc;

  logic [SCORE_W-1:0] sl_n;
  logic [SCORE_W-1:0] sr_n;
  logic               dir_n;
  logic               win_n;
  logic               err_n;
  logic               step_n;
  logic               brst_n;

  assign st_edge = start_btn & ~start_q;
  assign timeout = (state == ST_WAIT) && (tcnt == TMO);
  assign hit_l   = phys.phys_done & phys.miss_l & ~phys.miss_r;
  assign hit_r   = phys.phys_done & phys.miss_r & ~phys.miss_l;
  assign hit_b   = phys.phys_done & phys.miss_l & phys.miss_r;
  assign sl_inc  = score_l + 1'b1;
  assign sr_inc  = score_r + 1'b1;

  assign game_state = state;

  assign f_load = (state_nxt != state) &&
                  (state_nxt == ST_SERVE || state_nxt == ST_SCORED);
  assign f_val  = (state_nxt == ST_SERVE) ? FW'(SERVE_LD) : FW'(PAUSE_LD);

  pong_game_ctrl_frame_timer #(.W(FW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (f_load),
    .load_val (f_val),
    .tick     (frame_tick),
    .expire   (f_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_OVER: begin
        if (st_edge) state_nxt = ST_SERVE;
      end
      ST_SERVE: begin
        if (f_exp) state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        if (frame_tick) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (hit_l)
          state_nxt = (sr_inc == WIN) ? ST_OVER : ST_SCORED;
        else if (hit_r)
          state_nxt = (sl_inc == WIN) ? ST_OVER : ST_SCORED;
        else if (hit_b)
          state_nxt = ST_SCORED;
        else if (phys.phys_done || timeout)
          state_nxt = ST_PLAY;
      end
      ST_SCORED: begin
        if (f_exp) state_nxt = ST_SERVE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    sl_n   = score_l;
    sr_n   = score_r;
    dir_n  = phys.serve_dir;
    win_n  = winner;
    err_n  = step_err;
    step_n = 1'b0;
    brst_n = 1'b0;
    unique case (state)
      ST_IDLE, ST_OVER: begin
        if (st_edge) begin
          sl_n   = '0;
          sr_n   = '0;
          dir_n  = 1'b1;
          win_n  = 1'b0;
          err_n  = 1'b0;
          brst_n = 1'b1;
        end
      end
      ST_PLAY: step_n = frame_tick;
      ST_WAIT: begin
        if (hit_l) begin
          sr_n  = sr_inc;
          dir_n = 1'b0;
          if (sr_inc == WIN) win_n = 1'b1;
        end else if (hit_r) begin
          sl_n  = sl_inc;
          dir_n = 1'b1;
          if (sl_inc == WIN) win_n = 1'b0;
        end else if (!phys.phys_done && timeout) begin
          err_n = 1'b1;
        end
      end
      ST_SCORED: brst_n = f_exp;
      default: ;
    endcase
  end

  // Step-timeout counter runs only while a physics step is outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (state != ST_WAIT) begin
      tcnt <= '0;
    end else if (!timeout) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q         <= 1'b0;
      score_l         <= '0;
      score_r         <= '0;
      phys.serve_dir  <= 1'b1;
      winner          <= 1'b0;
      step_err        <= 1'b0;
      phys.phys_step  <= 1'b0;
      phys.ball_reset <= 1'b0;
      paddle_en       <= 1'b0;
    end else begin
      start_q         <= start_btn;
      score_l         <= sl_n;
      score_r         <= sr_n;
      phys.serve_dir  <= dir_n;
      winner          <= win_n;
      step_err        <= err_n;
      phys.phys_step  <= step_n;
      phys.ball_reset <= brst_n;
      paddle_en       <= (state_nxt == ST_SERVE) ||
                         (state_nxt == ST_PLAY) ||
                         (state_nxt == ST_WAIT);
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: vector table plus
// hand-written sequences for scoring, wins, timeouts and reset.
module tb_pong_game_ctrl;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic       start_btn;
  logic       paddle_en;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic [2:0] game_state;
  logic       winner;
  logic       step_err;

  int n_chk;
  int n_err;

  pong_game_ctrl_if bus ();

  pong_game_ctrl #(
    .SCORE_W      (4),
    .WIN_SCORE    (3),
    .SERVE_FRAMES (3),
    .PAUSE_FRAMES (2),
    .STEP_TIMEOUT (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .start_btn  (start_btn),
    .phys       (bus.master),
    .paddle_en  (paddle_en),
    .score_l    (score_l),
    .score_r    (score_r),
    .game_state (game_state),
    .winner     (winner),
    .step_err   (step_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ft, st, pd, ml, mr;
    logic [2:0] e_state;
    logic       e_step, e_brst;
    logic [3:0] e_sl, e_sr;
    logic       e_dir, e_pad;
  } vec_t;

  vec_t vt[16];

  function automatic vec_t mk(
    input logic ft, st, pd, ml, mr,
    input int es, input logic estep, ebrst,
    input int esl, esr, input logic edir, epad);
    vec_t v;
    v.ft = ft; v.st = st; v.pd = pd; v.ml = ml; v.mr = mr;
    v.e_state = 3'(es); v.e_step = estep; v.e_brst = ebrst;
    v.e_sl = 4'(esl); v.e_sr = 4'(esr);
    v.e_dir = edir; v.e_pad = epad;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic done(input logic ml, input logic mr);
    bus.phys_done = 1'b1;
    bus.miss_l = ml;
    bus.miss_r = mr;
    cyc();
    bus.phys_done = 1'b0;
    bus.miss_l = 1'b0;
    bus.miss_r = 1'b0;
  endtask

  task automatic press();
    start_btn = 1'b1;
    cyc();
    start_btn = 1'b0;
  endtask

  task automatic serve_play(input string tag);
    repeat (3) tick();
    chk({tag, ".play"}, game_state, 2);
    tick();
    chk({tag, ".step"}, bus.phys_step, 1);
    chk({tag, ".wait"}, game_state, 3);
  endtask

  task automatic pause(input string tag);
    tick();
    chk({tag, ".brst0"}, bus.ball_reset, 0);
    tick();
    chk({tag, ".brst1"}, bus.ball_reset, 1);
    chk({tag, ".serve"}, game_state, 1);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    frame_tick = 1'b0;
    start_btn = 1'b0;
    bus.phys_done = 1'b0;
    bus.miss_l = 1'b0;
    bus.miss_r = 1'b0;

    vt[0]  = mk(0,1,0,0,0, 1,0,1, 0,0,1,1);
    vt[1]  = mk(0,1,0,0,0, 1,0,0, 0,0,1,1);
    vt[2]  = mk(1,0,0,0,0, 1,0,0, 0,0,1,1);
    vt[3]  = mk(1,0,0,0,0, 1,0,0, 0,0,1,1);
    vt[4]  = mk(0,0,0,0,0, 1,0,0, 0,0,1,1);
    vt[5]  = mk(1,0,0,0,0, 2,0,0, 0,0,1,1);
    vt[6]  = mk(1,0,0,0,0, 3,1,0, 0,0,1,1);
    vt[7]  = mk(1,0,0,0,0, 3,0,0, 0,0,1,1);
    vt[8]  = mk(0,0,0,1,0, 3,0,0, 0,0,1,1);
    vt[9]  = mk(0,0,0,0,0, 3,0,0, 0,0,1,1);
    vt[10] = mk(0,0,1,0,0, 2,0,0, 0,0,1,1);
    vt[11] = mk(1,0,0,0,0, 3,1,0, 0,0,1,1);
    vt[12] = mk(0,0,1,1,0, 4,0,0, 0,1,0,0);
    vt[13] = mk(1,0,0,0,0, 4,0,0, 0,1,0,0);
    vt[14] = mk(1,0,0,0,0, 1,0,1, 0,1,0,1);
    vt[15] = mk(0,0,0,0,0, 1,0,0, 0,1,0,1);

    repeat (3) @(posedge clk);
    #3;
    chk("rst.state", game_state, 0);
    chk("rst.score_l", score_l, 0);
    chk("rst.score_r", score_r, 0);
    chk("rst.dir", bus.serve_dir, 1);
    chk("rst.winner", winner, 0);
    chk("rst.err", step_err, 0);
    chk("rst.step", bus.phys_step, 0);
    chk("rst.brst", bus.ball_reset, 0);
    chk("rst.pad", paddle_en, 0);
    rst_n = 1'b1;
    cyc();
    chk("idle.state", game_state, 0);

    for (int i = 0; i < 16; i++) begin
      frame_tick = vt[i].ft;
      start_btn = vt[i].st;
      bus.phys_done = vt[i].pd;
      bus.miss_l = vt[i].ml;
      bus.miss_r = vt[i].mr;
      cyc();
      chk($sformatf("v%0d.state", i), game_state, vt[i].e_state);
      chk($sformatf("v%0d.step", i), bus.phys_step, vt[i].e_step);
      chk($sformatf("v%0d.brst", i), bus.ball_reset, vt[i].e_brst);
      chk($sformatf("v%0d.sl", i), score_l, vt[i].e_sl);
      chk($sformatf("v%0d.sr", i), score_r, vt[i].e_sr);
      chk($sformatf("v%0d.dir", i), bus.serve_dir, vt[i].e_dir);
      chk($sformatf("v%0d.pad", i), paddle_en, vt[i].e_pad);
    end
    frame_tick = 1'b0;
    start_btn = 1'b0;
    bus.phys_done = 1'b0;
    bus.miss_l = 1'b0;
    bus.miss_r = 1'b0;

    // Left player wins by three right-goal misses.
    for (int p = 1; p <= 3; p++) begin
      serve_play($sformatf("lw%0d", p));
      done(1'b0, 1'b1);
      chk($sformatf("lw%0d.sl", p), score_l, p);
      chk($sformatf("lw%0d.sr", p), score_r, 1);
      chk($sformatf("lw%0d.dir", p), bus.serve_dir, 1);
      if (p < 3) begin
        chk($sformatf("lw%0d.state", p), game_state, 4);
        pause($sformatf("lw%0d", p));
      end
    end
    chk("lw.over", game_state, 5);
    chk("lw.winner", winner, 0);
    chk("lw.pad", paddle_en, 0);
    cyc();
    chk("lw.hold", game_state, 5);
    press();
    chk("lw.restart", game_state, 1);
    chk("lw.brst", bus.ball_reset, 1);
    chk("lw.sl0", score_l, 0);
    chk("lw.sr0", score_r, 0);

    // Right player wins.
    for (int p = 1; p <= 3; p++) begin
      serve_play($sformatf("rw%0d", p));
      done(1'b1, 1'b0);
      chk($sformatf("rw%0d.sr", p), score_r, p);
      chk($sformatf("rw%0d.dir", p), bus.serve_dir, 0);
      if (p < 3) pause($sformatf("rw%0d", p));
    end
    chk("rw.over", game_state, 5);
    chk("rw.winner", winner, 1);
    chk("rw.sl", score_l, 0);
    press();
    chk("rw.winner0", winner, 0);
    chk("rw.dir1", bus.serve_dir, 1);
    chk("rw.sr0", score_r, 0);

    // Step timeout: still waiting after 8 cycles, recovers on the 9th.
    serve_play("to");
    repeat (8) cyc();
    chk("to.wait8", game_state, 3);
    chk("to.err8", step_err, 0);
    cyc();
    chk("to.play", game_state, 2);
    chk("to.err", step_err, 1);
    chk("to.sl", score_l, 0);
    chk("to.sr", score_r, 0);

    // phys_done on the timeout cycle takes priority.
    tick();
    chk("tw.step", bus.phys_step, 1);
    repeat (8) cyc();
    done(1'b1, 1'b0);
    chk("tw.state", game_state, 4);
    chk("tw.sr", score_r, 1);
    cyc();
    press();
    chk("tw.noedge", game_state, 4);
    chk("tw.sr_keep", score_r, 1);
    pause("tw");
    for (int p = 2; p <= 3; p++) begin
      serve_play($sformatf("tg%0d", p));
      done(1'b1, 1'b0);
      if (p < 3) pause($sformatf("tg%0d", p));
    end
    chk("tg.over", game_state, 5);
    chk("tg.err_sticky", step_err, 1);
    press();
    chk("tg.err_clr", step_err, 0);

    // Double miss keeps score and serve direction.
    serve_play("dm0");
    done(1'b1, 1'b0);
    chk("dm0.dir", bus.serve_dir, 0);
    pause("dm0");
    serve_play("dm");
    done(1'b1, 1'b1);
    chk("dm.state", game_state, 4);
    chk("dm.sl", score_l, 0);
    chk("dm.sr", score_r, 1);
    chk("dm.dir", bus.serve_dir, 0);
    pause("dm");

    // Reset during an outstanding step; late phys_done is ignored.
    serve_play("rs");
    rst_n = 1'b0;
    #1;
    chk("rs.state", game_state, 0);
    chk("rs.sr", score_r, 0);
    chk("rs.pad", paddle_en, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    done(1'b1, 1'b0);
    chk("rs.late", game_state, 0);
    chk("rs.late_sr", score_r, 0);
    chk("rs.late_step", bus.phys_step, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
